// File: rtl/ikari_video_pkg.sv
// Shared video definitions for the sprite line-buffer writer path.
package ikari_video_pkg;
  localparam int SPR_X_W     = 9;
  localparam int SPR_COLOR_W = 5;
  localparam int SPR_BPP     = 3;
  localparam int FD_W        = SPR_COLOR_W + SPR_BPP;
  localparam logic [FD_W-1:0] FD_IDLE = 8'hFF;

  typedef enum logic [1:0] {IDLE, LOAD, PIX} feed_state_e;
endpackage

// File: rtl/ikari_spr_pix_shifter.sv
// Sprite row register with per-slot pixel select.
// IKARI_FEED_HFLIP_EN adds a captured flip bit that reverses the pixel order.
module ikari_spr_pix_shifter
  import ikari_video_pkg::*;
#(
  parameter int PIX_PER_SPR = 16,
  localparam int IDX_W = $clog2(PIX_PER_SPR)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [PIX_PER_SPR*SPR_BPP-1:0]   gfx_in,
`ifdef IKARI_FEED_HFLIP_EN
  input  logic                             hflip_in,
`endif
  input  logic [IDX_W-1:0]                 sel,
  output logic [SPR_BPP-1:0]               pix
);
  logic [PIX_PER_SPR-1:0][SPR_BPP-1:0] row_q;
  logic [IDX_W-1:0]                    idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       row_q <= '0;
    else if (load) row_q <= gfx_in;
  end

`ifdef IKARI_FEED_HFLIP_EN
  logic hflip_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       hflip_q <= 1'b0;
    else if (load) hflip_q <= hflip_in;
  end
  assign idx = hflip_q ? IDX_W'(PIX_PER_SPR-1) - sel : sel;
`else
  assign idx = sel;
`endif

  assign pix = row_q[idx];
endmodule

// File: rtl/ikari_sprite_line_feeder.sv
// Serialises one sprite row per handshake into line-buffer load/data slots on ck0_cen.
// Optional IKARI_FEED_HFLIP_EN enables horizontal flip of the emitted pixel order.
module ikari_sprite_line_feeder
  import ikari_video_pkg::*;
#(
  parameter int                 PIX_PER_SPR = 16,
  parameter logic [SPR_BPP-1:0] TRANSP      = 3'b111
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ck0_cen,
  input  logic                           line_start,
  input  logic                           spr_valid,
  output logic                           spr_ready,
  input  logic [SPR_X_W-1:0]             spr_x,
  input  logic [SPR_COLOR_W-1:0]         spr_color,
  input  logic [PIX_PER_SPR*SPR_BPP-1:0] spr_gfx,
  input  logic                           spr_hflip,
  output logic [SPR_X_W-1:0]             fly,
  output logic                           fck_ldn,
  output logic [FD_W-1:0]                fd,
  output logic                           busy
);
  localparam int CNT_W = $clog2(PIX_PER_SPR);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_SPR-1);
  // Transparent pixels pass through untouched; the buffer drops them.
  localparam logic [SPR_BPP-1:0] unused_transp_code = TRANSP;

  feed_state_e             state;
  logic [CNT_W-1:0]        pix_cnt;
  logic [SPR_X_W-1:0]      x_q;
  logic [SPR_COLOR_W-1:0]  color_q;
  logic [SPR_BPP-1:0]      pix;
  logic                    accept;

  assign spr_ready = (state == IDLE) & ~line_start;
  assign accept    = spr_valid & spr_ready;

  ikari_spr_pix_shifter #(.PIX_PER_SPR(PIX_PER_SPR)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .gfx_in   (spr_gfx),
`ifdef IKARI_FEED_HFLIP_EN
    .hflip_in (spr_hflip),
`endif
    .sel      (pix_cnt),
    .pix      (pix)
  );

`ifndef IKARI_FEED_HFLIP_EN
  logic unused_hflip;
  assign unused_hflip = spr_hflip;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pix_cnt <= '0;
      x_q     <= '0;
      color_q <= '0;
      fly     <= '0;
      fck_ldn <= 1'b1;
      fd      <= FD_IDLE;
      busy    <= 1'b0;
    end else if (line_start) begin
      state   <= IDLE;
      pix_cnt <= '0;
      fck_ldn <= 1'b1;
      fd      <= FD_IDLE;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A slot coinciding with the handshake stays idle; LOAD uses the next one.
          if (ck0_cen) begin
            fck_ldn <= 1'b1;
            fd      <= FD_IDLE;
          end
          if (spr_valid) begin
            x_q     <= spr_x;
            color_q <= spr_color;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: if (ck0_cen) begin
          fck_ldn <= 1'b0;
          fly     <= x_q;
          fd      <= FD_IDLE;
          pix_cnt <= '0;
          state   <= PIX;
        end
        PIX: if (ck0_cen) begin
          fck_ldn <= 1'b1;
          fd      <= {color_q, pix};
          pix_cnt <= pix_cnt + CNT_W'(1);
          if (pix_cnt == LAST_PIX) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
